// File: rtl/scheduler_pkg.sv
// Shared scheduler constants, PIFO entry field layout and write-side FSM encodings.
package scheduler_pkg;

    localparam int ADDR_WIDTH       = 12;
    localparam int RANK_WIDTH       = 19;
    localparam int PIFO_ENTRY_WIDTH = 32;

    localparam int VALID_POS = 31;
    localparam int RANK_LSB  = 12;
    localparam int ADDR_LSB  = 0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WRITE   = 2'd1,
        ST_DISCARD = 2'd2
    } wr_state_t;

endpackage

// File: rtl/buffer_occupancy_ctr.sv
// Chunk-buffer occupancy up/down counter with packet rollback, underflow detect
// and a registered almost-full flag.
module buffer_occupancy_ctr #(
    parameter int ADDR_WIDTH     = 12,
    parameter int MAX_PKT_CHUNKS = 48
) (
    input  logic                  axis_aclk,
    input  logic                  axis_reset,
    input  logic                  inc,
    input  logic                  rel,
    input  logic                  rollback,
    input  logic [ADDR_WIDTH:0]   rollback_amt,
    output logic [ADDR_WIDTH:0]   occupancy,
    output logic                  almost_full,
    output logic                  underflow
);

    localparam logic [ADDR_WIDTH:0] DEPTH     = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] AF_THRESH = (ADDR_WIDTH + 1)'(MAX_PKT_CHUNKS);

    logic [ADDR_WIDTH:0] occ_q;
    logic [ADDR_WIDTH:0] occ_n;
    logic                af_q;
    logic                dec_ok;

    // A release against an empty buffer is dropped and only flagged.
    always_comb begin
        dec_ok    = rel & (occ_q != '0);
        underflow = rel & (occ_q == '0);
        occ_n     = occ_q + (ADDR_WIDTH + 1)'(inc) - (ADDR_WIDTH + 1)'(dec_ok)
                    - (rollback ? rollback_amt : '0);
    end

    always_ff @(posedge axis_aclk or posedge axis_reset) begin
        if (axis_reset) begin
            occ_q <= '0;
            af_q  <= 1'b0;
        end else begin
            occ_q <= occ_n;
            af_q  <= (DEPTH - occ_n) < AF_THRESH;
        end
    end

    assign occupancy   = occ_q;
    assign almost_full = af_q;

endmodule

// File: rtl/queue_buffer_writer.sv
// Per-queue store-and-forward writer: places AXIS beats into the ring buffer and
// emits a PIFO root entry once the whole packet has been stored.
module queue_buffer_writer #(
    parameter int C_S_AXIS_DATA_WIDTH = 256,
    parameter int ADDR_WIDTH          = scheduler_pkg::ADDR_WIDTH,
    parameter int RANK_WIDTH          = scheduler_pkg::RANK_WIDTH,
    parameter int MAX_PKT_CHUNKS      = 48
) (
    input  logic                              axis_aclk,
    input  logic                              axis_reset,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic                              s_axis_tvalid,
    input  logic                              s_axis_tready,
    input  logic                              s_axis_tlast,
    input  logic [RANK_WIDTH-1:0]             s_axis_trank,
    input  logic                              ctl_buffer_wr_en,
    input  logic                              ctl_pifo_in_en,
    input  logic                              s_buf_release,
    output logic                              m_buf_wr_en,
    output logic [ADDR_WIDTH-1:0]             m_buf_wr_addr,
    output logic [C_S_AXIS_DATA_WIDTH:0]      m_buf_wr_data,
    output logic                              m_pifo_entry_valid,
    output logic [RANK_WIDTH+ADDR_WIDTH:0]    m_pifo_entry,
    output logic                              m_buffer_almost_full,
    output logic                              m_overflow_err
);

    import scheduler_pkg::*;

    localparam int                  ENTRY_W = 1 + RANK_WIDTH + ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH   = {1'b1, {ADDR_WIDTH{1'b0}}};

    wr_state_t               state_q, state_n;
    logic [ADDR_WIDTH-1:0]   wr_ptr_q, wr_ptr_n;
    logic [ADDR_WIDTH-1:0]   head_q, head_n;
    logic [RANK_WIDTH-1:0]   rank_q, rank_n;
    logic [ADDR_WIDTH:0]     pkt_q, pkt_n;
    logic                    ev_q, ev_n;
    logic [ENTRY_W-1:0]      entry_q, entry_n;
    logic                    err_q, err_n;

    logic [ADDR_WIDTH:0]     occupancy;
    logic                    almost_full;
    logic                    underflow;
    logic                    full;
    logic                    acc;
    logic                    attempt;
    logic                    wr_fire;
    logic                    ovf;
    logic                    rollback;

    assign full    = (occupancy == DEPTH);
    assign acc     = s_axis_tvalid & s_axis_tready & ctl_buffer_wr_en;
    assign attempt = acc & ((state_q == ST_WRITE) | ((state_q == ST_IDLE) & ctl_pifo_in_en));
    assign wr_fire = attempt & ~full;
    assign ovf     = attempt & full;

    buffer_occupancy_ctr #(
        .ADDR_WIDTH     (ADDR_WIDTH),
        .MAX_PKT_CHUNKS (MAX_PKT_CHUNKS)
    ) u_occ (
        .axis_aclk    (axis_aclk),
        .axis_reset   (axis_reset),
        .inc          (wr_fire),
        .rel          (s_buf_release),
        .rollback     (rollback),
        .rollback_amt (pkt_q),
        .occupancy    (occupancy),
        .almost_full  (almost_full),
        .underflow    (underflow)
    );

    always_comb begin
        state_n  = state_q;
        wr_ptr_n = wr_ptr_q;
        head_n   = head_q;
        rank_n   = rank_q;
        pkt_n    = pkt_q;
        ev_n     = 1'b0;
        entry_n  = entry_q;
        err_n    = err_q | ovf | underflow;
        rollback = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // An overflowing SOP has nothing stored yet, so there is nothing to roll back.
                if (acc && ctl_pifo_in_en) begin
                    if (full) begin
                        if (!s_axis_tlast) state_n = ST_DISCARD;
                    end else begin
                        head_n   = wr_ptr_q;
                        rank_n   = s_axis_trank;
                        pkt_n    = (ADDR_WIDTH + 1)'(1);
                        wr_ptr_n = wr_ptr_q + 1'b1;
                        if (s_axis_tlast) begin
                            ev_n    = 1'b1;
                            entry_n = {1'b1, s_axis_trank, wr_ptr_q};
                        end else begin
                            state_n = ST_WRITE;
                        end
                    end
                end
            end
            ST_WRITE: begin
                if (acc) begin
                    if (full) begin
                        rollback = 1'b1;
                        wr_ptr_n = head_q;
                        state_n  = s_axis_tlast ? ST_IDLE : ST_DISCARD;
                    end else begin
                        pkt_n    = pkt_q + 1'b1;
                        wr_ptr_n = wr_ptr_q + 1'b1;
                        if (s_axis_tlast) begin
                            ev_n    = 1'b1;
                            entry_n = {1'b1, rank_q, head_q};
                            state_n = ST_IDLE;
                        end
                    end
                end
            end
            ST_DISCARD: begin
                if (acc && s_axis_tlast) state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge axis_aclk or posedge axis_reset) begin
        if (axis_reset) begin
            state_q  <= ST_IDLE;
            wr_ptr_q <= '0;
            head_q   <= '0;
            rank_q   <= '0;
            pkt_q    <= '0;
            ev_q     <= 1'b0;
            entry_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_n;
            wr_ptr_q <= wr_ptr_n;
            head_q   <= head_n;
            rank_q   <= rank_n;
            pkt_q    <= pkt_n;
            ev_q     <= ev_n;
            entry_q  <= entry_n;
            err_q    <= err_n;
        end
    end

    assign m_buf_wr_en          = wr_fire;
    assign m_buf_wr_addr        = wr_ptr_q;
    assign m_buf_wr_data        = {s_axis_tlast, s_axis_tdata};
    assign m_pifo_entry_valid   = ev_q;
    assign m_pifo_entry         = entry_q;
    assign m_buffer_almost_full = almost_full;
    assign m_overflow_err       = err_q;

endmodule

// File: tb/tb_queue_buffer_writer.sv
// Directed bench for queue_buffer_writer: vector table for basic packets, then
// hand-written sequences for almost-full, wrap, overflow rollback and reset.
module tb_queue_buffer_writer;

    logic         clk = 1'b0;
    logic         rst;
    logic [255:0] tdata;
    logic         tvalid, tready, tlast;
    logic [18:0]  trank;
    logic         wen, pen, rel;
    logic         wr_en;
    logic [11:0]  wr_addr;
    logic [256:0] wr_data;
    logic         ev;
    logic [31:0]  entry;
    logic         af;
    logic         err;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    queue_buffer_writer #(
        .C_S_AXIS_DATA_WIDTH (256),
        .ADDR_WIDTH          (12),
        .RANK_WIDTH          (19),
        .MAX_PKT_CHUNKS      (48)
    ) dut (
        .axis_aclk            (clk),
        .axis_reset           (rst),
        .s_axis_tdata         (tdata),
        .s_axis_tvalid        (tvalid),
        .s_axis_tready        (tready),
        .s_axis_tlast         (tlast),
        .s_axis_trank         (trank),
        .ctl_buffer_wr_en     (wen),
        .ctl_pifo_in_en       (pen),
        .s_buf_release        (rel),
        .m_buf_wr_en          (wr_en),
        .m_buf_wr_addr        (wr_addr),
        .m_buf_wr_data        (wr_data),
        .m_pifo_entry_valid   (ev),
        .m_pifo_entry         (entry),
        .m_buffer_almost_full (af),
        .m_overflow_err       (err)
    );

    typedef struct {
        logic         vld, rdy, wen, pen, last;
        logic [18:0]  rank;
        logic [255:0] data;
        logic         rel;
        logic         x_wr;
        logic [11:0]  x_addr;
        logic         x_ev;
        logic [31:0]  x_entry;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [259:0] act, input logic [259:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic p, input logic l, input logic [18:0] r,
                         input logic rl);
        @(posedge clk);
        #1;
        tvalid = v; tready = v; wen = v; pen = p; tlast = l; trank = r; rel = rl;
        tdata  = {8{$urandom()}};
        @(negedge clk);
    endtask

    task automatic idle_cycle();
        drive(1'b0, 1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic send_pkt(input int n, input logic [18:0] r, input logic rl);
        for (int i = 0; i < n; i++) drive(1'b1, i == 0, i == n - 1, r, rl);
        idle_cycle();
    endtask

    initial begin
        rst = 1'b1;
        tdata = '0; tvalid = 0; tready = 0; tlast = 0; trank = '0; wen = 0; pen = 0; rel = 0;

        //            vld rdy wen pen lst rank      data        rel  wr  addr  ev  entry
        vecs[0] = '{1'b0,1'b0,1'b0,1'b0,1'b0,19'h0,    256'h0,    1'b0,1'b0,12'd0,1'b0,32'h0};
        vecs[1] = '{1'b1,1'b1,1'b1,1'b1,1'b0,19'h00123,256'hA0,   1'b0,1'b1,12'd0,1'b0,32'h0};
        vecs[2] = '{1'b1,1'b1,1'b1,1'b0,1'b0,19'h0,    256'hA1,   1'b0,1'b1,12'd1,1'b0,32'h0};
        vecs[3] = '{1'b1,1'b0,1'b1,1'b0,1'b0,19'h0,    256'hBAD,  1'b0,1'b0,12'd2,1'b0,32'h0};
        vecs[4] = '{1'b1,1'b1,1'b1,1'b0,1'b1,19'h0,    256'hA2,   1'b0,1'b1,12'd2,1'b0,32'h0};
        vecs[5] = '{1'b0,1'b0,1'b0,1'b0,1'b0,19'h0,    256'h0,    1'b0,1'b0,12'd3,1'b1,32'h80123000};
        vecs[6] = '{1'b1,1'b1,1'b1,1'b0,1'b1,19'h0,    256'hC0,   1'b0,1'b0,12'd3,1'b0,32'h0};
        vecs[7] = '{1'b1,1'b1,1'b1,1'b1,1'b1,19'h5,    256'hD0,   1'b0,1'b1,12'd3,1'b0,32'h0};
        vecs[8] = '{1'b0,1'b0,1'b0,1'b0,1'b0,19'h0,    256'h0,    1'b0,1'b0,12'd4,1'b1,32'h80005003};
        vecs[9] = '{1'b1,1'b1,1'b0,1'b1,1'b1,19'h7,    256'hE0,   1'b0,1'b0,12'd4,1'b0,32'h0};

        // Reset state
        @(negedge clk); @(negedge clk);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_ev", ev, 0);
        chk("rst_entry", entry, 0);
        chk("rst_af", af, 0);
        chk("rst_err", err, 0);
        @(posedge clk); #1 rst = 1'b0;

        // Basic packets from the vector table
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            tvalid = vecs[i].vld; tready = vecs[i].rdy; wen = vecs[i].wen; pen = vecs[i].pen;
            tlast = vecs[i].last; trank = vecs[i].rank; tdata = vecs[i].data; rel = vecs[i].rel;
            @(negedge clk);
            chk($sformatf("v%0d_wr_en", i), wr_en, vecs[i].x_wr);
            if (vecs[i].x_wr) begin
                chk($sformatf("v%0d_addr", i), wr_addr, vecs[i].x_addr);
                chk($sformatf("v%0d_data", i), wr_data, {vecs[i].last, vecs[i].data});
            end
            chk($sformatf("v%0d_ev", i), ev, vecs[i].x_ev);
            if (vecs[i].x_ev) chk($sformatf("v%0d_entry", i), entry, vecs[i].x_entry);
        end
        idle_cycle();
        chk("occ_after_table", dut.occupancy, 4);
        chk("err_after_table", err, 0);

        // Almost-full threshold: ptr 4, occ 4 -> fill to 4048
        send_pkt(4044, 19'h1, 1'b0);
        chk("occ_4048", dut.occupancy, 4048);
        chk("af_4048", af, 0);
        drive(1'b1, 1'b1, 1'b1, 19'h2, 1'b0);
        chk("af_same_cycle", af, 0);
        idle_cycle();
        chk("af_4049", af, 1);
        drive(1'b0, 1'b0, 1'b0, '0, 1'b1);
        chk("af_rel_same_cycle", af, 1);
        idle_cycle();
        chk("af_after_rel", af, 0);
        drive(1'b1, 1'b1, 1'b1, 19'h2, 1'b1);
        idle_cycle();
        chk("occ_wr_rel", dut.occupancy, 4048);
        chk("af_wr_rel", af, 0);

        // Pointer wrap: ptr 4050 -> 4094 with occupancy held at 4048
        send_pkt(44, 19'h1, 1'b1);
        chk("occ_hold", dut.occupancy, 4048);
        drive(1'b1, 1'b1, 1'b0, 19'h7ABCD, 1'b0);
        chk("wrap_addr0", wr_addr, 4094);
        chk("wrap_wr0", wr_en, 1);
        drive(1'b1, 1'b0, 1'b0, '0, 1'b0);
        chk("wrap_addr1", wr_addr, 4095);
        drive(1'b1, 1'b0, 1'b1, '0, 1'b0);
        chk("wrap_addr2", wr_addr, 0);
        chk("wrap_last", wr_data[256], 1);
        idle_cycle();
        chk("wrap_ev", ev, 1);
        chk("wrap_entry", entry, 32'hFABCDFFE);

        // Overflow rollback: occ 4051 -> 4094, ptr 1 -> 44
        send_pkt(43, 19'h1, 1'b0);
        chk("occ_4094", dut.occupancy, 4094);
        drive(1'b1, 1'b1, 1'b0, 19'h55, 1'b0);
        chk("ovf_wr0", wr_en, 1);
        chk("ovf_addr0", wr_addr, 44);
        drive(1'b1, 1'b0, 1'b0, '0, 1'b0);
        chk("ovf_wr1", wr_en, 1);
        chk("ovf_addr1", wr_addr, 45);
        drive(1'b1, 1'b0, 1'b0, '0, 1'b0);
        chk("ovf_wr2", wr_en, 0);
        chk("ovf_err_not_yet", err, 0);
        drive(1'b1, 1'b0, 1'b1, '0, 1'b0);
        chk("ovf_wr3", wr_en, 0);
        chk("ovf_err", err, 1);
        idle_cycle();
        chk("ovf_no_ev0", ev, 0);
        chk("ovf_occ", dut.occupancy, 4094);
        idle_cycle();
        chk("ovf_no_ev1", ev, 0);
        drive(1'b1, 1'b1, 1'b1, 19'h3, 1'b0);
        chk("ovf_ptr_rolled", wr_addr, 44);
        chk("ovf_next_wr", wr_en, 1);
        idle_cycle();
        chk("ovf_next_ev", ev, 1);
        chk("ovf_next_entry", entry, 32'h8000302C);
        chk("ovf_err_sticky", err, 1);

        // Reset mid-packet
        drive(1'b1, 1'b1, 1'b0, 19'h44, 1'b0);
        chk("rm_addr0", wr_addr, 45);
        @(posedge clk);
        #1;
        rst = 1'b1; pen = 1'b0;
        @(negedge clk);
        chk("rm_wr_en", wr_en, 0);
        chk("rm_ev", ev, 0);
        chk("rm_entry", entry, 0);
        chk("rm_af", af, 0);
        chk("rm_err", err, 0);
        chk("rm_occ", dut.occupancy, 0);
        @(posedge clk);
        #1;
        rst = 1'b0; tvalid = 0; tready = 0; wen = 0; tlast = 0;
        idle_cycle();
        chk("rm_no_ev", ev, 0);
        drive(1'b1, 1'b1, 1'b1, 19'h9, 1'b0);
        chk("rm_new_wr", wr_en, 1);
        chk("rm_new_addr", wr_addr, 0);
        idle_cycle();
        chk("rm_new_ev", ev, 1);
        chk("rm_new_entry", entry, 32'h80009000);
        idle_cycle();
        chk("rm_ev_one_cycle", ev, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
